// File: rtl/avg_level_pkg.sv
// Shared definitions for the windowed-average level detector family.
// Holds the FSM state encoding, default datapath widths and small helpers.
// Imported by avg_level_detect and its sub-modules.
package avg_level_pkg;

  // Default datapath widths: an 8-tap window of 8-bit samples gives an
  // 11-bit sum, divided by 2^3 back to an 8-bit average.
  localparam int SUM_W_DEF = 11;
  localparam int SHIFT_DEF = 3;
  localparam int AVG_W_DEF = 8;

  // Counter width; HOLD is limited to 1..15 so a 4-bit counter never wraps.
  localparam int CNT_W = 4;

  // Debounce FSM states. The encoding is shared with the logging side,
  // so the values are fixed explicitly.
  typedef enum logic [1:0] {
    LOW      = 2'd0,
    ARM_HIGH = 2'd1,
    HIGH     = 2'd2,
    ARM_LOW  = 2'd3
  } level_state_t;

  // True for the states in which the debounced level reads as "above".
  function automatic logic is_high_level(input level_state_t s);
    return (s == HIGH) || (s == ARM_LOW);
  endfunction

  // True for the states from which a transition into HIGH is a fresh rise
  // (as opposed to a return from ARM_LOW inside the same episode).
  function automatic logic is_low_level(input level_state_t s);
    return (s == LOW) || (s == ARM_HIGH);
  endfunction

endpackage : avg_level_pkg

// File: rtl/round_shift_sat.sv
// Combinational round-to-nearest divide by 2^SHIFT with saturation to AVG_W.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input every cycle.
module round_shift_sat #(
  parameter int SUM_W = 11,
  parameter int SHIFT = 3,
  parameter int AVG_W = 8
) (
  input  logic [SUM_W-1:0] i_sum,
  output logic [AVG_W-1:0] o_avg
);

  // Half an LSB of the result, added before the shift so the divide rounds
  // to nearest (ties round up). No rounding term when nothing is shifted.
  localparam logic [SUM_W:0] RND =
    (SHIFT > 0) ? ((SUM_W + 1)'(1) << (SHIFT - 1)) : '0;

  // One extra bit so the rounding add can never overflow.
  logic [SUM_W:0] w_ext;
  logic [SUM_W:0] w_shr;

  assign w_ext = {1'b0, i_sum} + RND;
  assign w_shr = w_ext >> SHIFT;

  generate
    if (SUM_W + 1 > AVG_W) begin : g_sat
      // Any set bit above the AVG_W field means the result does not fit:
      // clamp to the all-ones maximum instead of letting it wrap.
      logic w_ovf;
      assign w_ovf = |w_shr[SUM_W:AVG_W];
      assign o_avg = w_ovf ? {AVG_W{1'b1}} : w_shr[AVG_W-1:0];
    end else begin : g_nosat
      // Output is at least as wide as the shifted sum: overflow impossible.
      assign o_avg = AVG_W'(w_shr);
    end
  endgenerate

endmodule : round_shift_sat

// File: rtl/avg_level_detect.sv
// Rounded window average plus hysteresis/debounce level detector with peak capture.
// Latency: sample -> o_avg 1 cycle; sample -> o_above/o_rise/o_fall/o_peak 2 cycles.
// Backpressure: none; every i_valid sample is consumed, invalid cycles freeze the FSM.
module avg_level_detect
  import avg_level_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int AVG_W = AVG_W_DEF,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SUM_W-1:0] i_sum,
  input  logic             i_valid,
  input  logic [AVG_W-1:0] i_th_hi,
  input  logic [AVG_W-1:0] i_th_lo,
  output logic [AVG_W-1:0] o_avg,
  output logic             o_avg_valid,
  output logic             o_above,
  output logic             o_rise,
  output logic             o_fall,
  output logic [AVG_W-1:0] o_peak
);

  // HOLD as a counter-width constant; with HOLD == 1 the ARM states are skipped.
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD);
  localparam logic             HOLD_ONE = (HOLD == 1);

  // ---------------------------------------------------------------------------
  // Average stage
  // ---------------------------------------------------------------------------
  logic [AVG_W-1:0] w_avg_rnd;
  logic [AVG_W-1:0] r_avg;
  logic             r_avg_valid;

  round_shift_sat #(
    .SUM_W (SUM_W),
    .SHIFT (SHIFT),
    .AVG_W (AVG_W)
  ) u_round (
    .i_sum (i_sum),
    .o_avg (w_avg_rnd)
  );

  // Register the rounded average on valid samples; hold it otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= i_valid;
      if (i_valid) begin
        r_avg <= w_avg_rnd;
      end
    end
  end

  assign o_avg       = r_avg;
  assign o_avg_valid = r_avg_valid;

  // ---------------------------------------------------------------------------
  // Threshold qualification
  // ---------------------------------------------------------------------------
  // An inverted pair (lo > hi) would let one sample qualify for both
  // directions; clamping lo to hi keeps the hysteresis band non-negative.
  logic [AVG_W-1:0] w_th_lo_eff;
  logic             w_q_hi;
  logic             w_q_lo;

  assign w_th_lo_eff = (i_th_lo < i_th_hi) ? i_th_lo : i_th_hi;
  assign w_q_hi      = (r_avg >= i_th_hi);
  assign w_q_lo      = (r_avg <= w_th_lo_eff);

  // ---------------------------------------------------------------------------
  // Debounce FSM, counter and peak tracker
  // ---------------------------------------------------------------------------
  level_state_t     r_state;
  level_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [AVG_W-1:0] r_peak;
  logic [AVG_W-1:0] w_peak_nxt;
  logic             w_rise;
  logic             w_fall;

  logic             r_above;
  logic             r_rise;
  logic             r_fall;
  logic [AVG_W-1:0] r_peak_out;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // State, counter and pending peak register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOW;
      r_cnt   <= '0;
      r_peak  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_peak  <= w_peak_nxt;
    end
  end

  // Next state, counter and event decode; only valid averages move the FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_peak_nxt  = r_peak;

    if (r_avg_valid) begin
      unique case (r_state)
        LOW: begin
          if (w_q_hi) begin
            if (HOLD_ONE) begin
              w_state_nxt = HIGH;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ARM_HIGH;
              w_cnt_nxt   = CNT_W'(1);
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end

        ARM_HIGH: begin
          if (w_q_hi) begin
            if (w_cnt_inc == HOLD_C) begin
              w_state_nxt = HIGH;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = LOW;
            w_cnt_nxt   = '0;
          end
        end

        HIGH: begin
          if (w_q_lo) begin
            if (HOLD_ONE) begin
              w_state_nxt = LOW;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ARM_LOW;
              w_cnt_nxt   = CNT_W'(1);
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end

        ARM_LOW: begin
          if (w_q_lo) begin
            if (w_cnt_inc == HOLD_C) begin
              w_state_nxt = LOW;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            // Back to HIGH within the same episode: no rise, peak kept.
            w_state_nxt = HIGH;
            w_cnt_nxt   = '0;
          end
        end

        default: begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
        end
      endcase

      // A rise is entry to HIGH from the low side only; a fall is leaving
      // the high side for LOW (from ARM_LOW, or straight from HIGH when
      // HOLD == 1).
      w_rise = is_low_level(r_state) && (w_state_nxt == HIGH);
      w_fall = is_high_level(r_state) && (w_state_nxt == LOW);

      // A new episode starts its peak at the sample that completed the rise;
      // inside an episode the peak only grows.
      if (w_rise) begin
        w_peak_nxt = r_avg;
      end else if (is_high_level(r_state)) begin
        w_peak_nxt = (r_avg > r_peak) ? r_avg : r_peak;
      end
    end
  end

  // Registered level, one-cycle event pulses and published episode peak.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_above    <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_peak_out <= '0;
    end else begin
      r_above <= is_high_level(w_state_nxt);
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      // The peak includes the closing sample of the episode.
      if (w_fall) begin
        r_peak_out <= w_peak_nxt;
      end
    end
  end

  assign o_above = r_above;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_peak  = r_peak_out;

endmodule : avg_level_detect

// File: tb/tb_avg_level_detect.sv
// Directed bench for avg_level_detect: per-cycle vector table plus a latency check.
// Each table row is driven for one clock; outputs are compared 1 ns after the edge.
// Expected values are hand-derived from the described behaviour (HOLD = 4).
module tb_avg_level_detect;

  logic        clk;
  logic        rst;
  logic [10:0] i_sum;
  logic        i_valid;
  logic [7:0]  i_th_hi;
  logic [7:0]  i_th_lo;
  logic [7:0]  o_avg;
  logic        o_avg_valid;
  logic        o_above;
  logic        o_rise;
  logic        o_fall;
  logic [7:0]  o_peak;

  avg_level_detect #(
    .SUM_W (11),
    .SHIFT (3),
    .AVG_W (8),
    .HOLD  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_sum       (i_sum),
    .i_valid     (i_valid),
    .i_th_hi     (i_th_hi),
    .i_th_lo     (i_th_lo),
    .o_avg       (o_avg),
    .o_avg_valid (o_avg_valid),
    .o_above     (o_above),
    .o_rise      (o_rise),
    .o_fall      (o_fall),
    .o_peak      (o_peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [10:0] sum;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic        chk_avg;
    logic        e_vld;
    logic [7:0]  e_avg;
    logic        e_above;
    logic        e_rise;
    logic        e_fall;
    logic [7:0]  e_peak;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp;
  int   n_err;
  logic [7:0] cur_hi;
  logic [7:0] cur_lo;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic push(input logic r, input logic v, input int sum, input int e_avg,
                      input logic ab, input logic ri, input logic fa, input int pk);
    vec_t t;
    t.rst     = r;
    t.vld     = v;
    t.sum     = 11'(sum);
    t.hi      = cur_hi;
    t.lo      = cur_lo;
    t.chk_avg = r | v;
    t.e_vld   = v & ~r;
    t.e_avg   = r ? 8'd0 : 8'(e_avg);
    t.e_above = ab;
    t.e_rise  = ri;
    t.e_fall  = fa;
    t.e_peak  = 8'(pk);
    tbl.push_back(t);
  endtask

  // Valid sample given as an exact average (sum = avg * 8).
  task automatic smp(input int avg, input logic ab, input logic ri, input logic fa,
                     input int pk);
    push(1'b0, 1'b1, avg * 8, avg, ab, ri, fa, pk);
  endtask

  // Idle (invalid) cycle.
  task automatic idl(input logic ab, input logic ri, input logic fa, input int pk);
    push(1'b0, 1'b0, 0, 0, ab, ri, fa, pk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    i_sum   = '0;
    i_valid = 1'b0;
    i_th_hi = 8'd0;
    i_th_lo = 8'd0;

    // Reset and rounding.
    cur_hi = 8'd255; cur_lo = 8'd0;
    push(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
    push(1'b0, 1'b1, 11,   1,   0, 0, 0, 0);
    push(1'b0, 1'b1, 12,   2,   0, 0, 0, 0);
    push(1'b0, 1'b1, 2047, 255, 0, 0, 0, 0);
    idl(0, 0, 0, 0);
    push(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);

    // Rise debounce with an interrupting 90.
    cur_hi = 8'd100; cur_lo = 8'd50;
    smp(120, 0, 0, 0, 0);
    smp(120, 0, 0, 0, 0);
    smp(120, 0, 0, 0, 0);
    smp(90,  0, 0, 0, 0);
    smp(120, 0, 0, 0, 0);
    smp(120, 0, 0, 0, 0);
    smp(120, 0, 0, 0, 0);
    smp(120, 0, 0, 0, 0);
    idl(1, 1, 0, 0);
    idl(1, 0, 0, 0);

    // Fall with peak; the 60 returns to HIGH without a rise.
    smp(150, 1, 0, 0, 0);
    smp(200, 1, 0, 0, 0);
    smp(40,  1, 0, 0, 0);
    smp(40,  1, 0, 0, 0);
    smp(60,  1, 0, 0, 0);
    smp(40,  1, 0, 0, 0);
    smp(40,  1, 0, 0, 0);
    smp(40,  1, 0, 0, 0);
    smp(40,  1, 0, 0, 0);
    idl(0, 0, 1, 200);
    idl(0, 0, 0, 200);

    // Valid gaps between qualifying samples keep the count.
    smp(120, 0, 0, 0, 200);
    idl(0, 0, 0, 200);
    smp(120, 0, 0, 0, 200);
    idl(0, 0, 0, 200);
    idl(0, 0, 0, 200);
    smp(120, 0, 0, 0, 200);
    smp(120, 0, 0, 0, 200);
    idl(1, 1, 0, 200);
    idl(1, 0, 0, 200);

    // Inverted thresholds: effective lo clamps to hi = 80.
    cur_hi = 8'd80; cur_lo = 8'd120;
    smp(85, 1, 0, 0, 200);
    smp(85, 1, 0, 0, 200);
    smp(85, 1, 0, 0, 200);
    smp(85, 1, 0, 0, 200);
    idl(1, 0, 0, 200);
    idl(1, 0, 0, 200);
    smp(80, 1, 0, 0, 200);
    smp(80, 1, 0, 0, 200);
    smp(80, 1, 0, 0, 200);
    smp(80, 1, 0, 0, 200);
    idl(0, 0, 1, 120);
    idl(0, 0, 0, 120);

    // Reset while in ARM_LOW with cnt = 3, with a 4th low sample at the reset edge.
    cur_hi = 8'd100; cur_lo = 8'd50;
    smp(150, 0, 0, 0, 120);
    smp(150, 0, 0, 0, 120);
    smp(150, 0, 0, 0, 120);
    smp(150, 0, 0, 0, 120);
    idl(1, 1, 0, 120);
    smp(30, 1, 0, 0, 120);
    smp(30, 1, 0, 0, 120);
    smp(30, 1, 0, 0, 120);
    idl(1, 0, 0, 120);
    push(1'b1, 1'b1, 240, 0, 0, 0, 0, 0);
    idl(0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst     = tbl[i].rst;
      i_valid = tbl[i].vld;
      i_sum   = tbl[i].sum;
      i_th_hi = tbl[i].hi;
      i_th_lo = tbl[i].lo;
      @(posedge clk);
      #1;
      chk("avg_valid", i, int'(o_avg_valid), int'(tbl[i].e_vld));
      if (tbl[i].chk_avg) chk("avg", i, int'(o_avg), int'(tbl[i].e_avg));
      chk("above", i, int'(o_above), int'(tbl[i].e_above));
      chk("rise",  i, int'(o_rise),  int'(tbl[i].e_rise));
      chk("fall",  i, int'(o_fall),  int'(tbl[i].e_fall));
      chk("peak",  i, int'(o_peak),  int'(tbl[i].e_peak));
    end

    // Hand-written: four back-to-back qualifying samples from LOW; the rise
    // must appear on the second edge after the last sample is presented.
    rst     = 1'b0;
    i_th_hi = 8'd100;
    i_th_lo = 8'd50;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_sum   = 11'd960;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b1;
    i_sum   = 11'd960;
    lat     = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_sum   = '0;
      if (o_rise && (lat == 0)) lat = c;
    end
    chk("rise_latency", 0, lat, 2);
    chk("above_after_rise", 0, int'(o_above), 1);
    chk("peak_held_after_rise", 0, int'(o_peak), 0);
    chk("avg_after_rise", 0, int'(o_avg), 120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_avg_level_detect

// File: doc/avg_level_detect.md
# avg_level_detect

Downstream consumer of the 8-tap windowed-sum stage. Each cycle, one 11-bit window sum arrives from that stage. This block:
- converts the sum to a rounded 8-bit average;
- runs a hysteresis/debounce state machine against programmable high and low thresholds;
- emits rise/fall event pulses, plus the peak average seen during each high episode.

Its outputs feed the control/logging logic.

## Interface

Parameters:
- SUM_W, 11: width of incoming window sum
- SHIFT, 3: log2 of window length (divide by 2^SHIFT)
- AVG_W, 8: width of average, thresholds, peak
- HOLD, 4: consecutive qualifying samples required to change level (1..15)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_sum  in  SUM_W  window sum from upstream stage
- i_valid  in  1  i_sum qualifier; samples with i_valid=0 are ignored
- i_th_hi  in  AVG_W  rise threshold (avg >= i_th_hi qualifies)
- i_th_lo  in  AVG_W  fall threshold (avg <= effective lo qualifies)
- o_avg  out  AVG_W  rounded average, registered
- o_avg_valid  out  1  o_avg qualifier
- o_above  out  1  debounced level, 1 while in HIGH or ARM_LOW
- o_rise  out  1  one-cycle pulse on entry to HIGH
- o_fall  out  1  one-cycle pulse on entry to LOW from ARM_LOW
- o_peak  out  AVG_W  max average of last completed high episode, held

## Operation

- Average: avg = (i_sum + 2^(SHIFT-1)) >> SHIFT, computed in SUM_W+1 bits.
  - Saturate to 2^AVG_W-1 if the result exceeds it.
  - Registered into o_avg on i_valid; o_avg_valid = registered i_valid.
- Effective lo = min(i_th_lo, i_th_hi). Thresholds are sampled each cycle and are not latched.
- FSM states: LOW, ARM_HIGH, HIGH, ARM_LOW. It advances only on cycles with o_avg_valid=1; otherwise it holds state and counter.
  - LOW: avg >= hi → cnt=1. If HOLD=1, go directly to HIGH; else go to ARM_HIGH.
  - ARM_HIGH:
    - avg >= hi → cnt++; on cnt reaching HOLD go to HIGH.
    - avg < hi → LOW, cnt=0.
  - HIGH: avg <= lo → cnt=1. If HOLD=1, go directly to LOW; else go to ARM_LOW.
  - ARM_LOW:
    - avg <= lo → cnt++; on cnt reaching HOLD go to LOW.
    - avg > lo → HIGH, cnt=0.
- Peak tracking:
  - On entry to HIGH, the peak register loads the current avg.
  - In HIGH and ARM_LOW, peak = max(peak, avg).
  - On the transition to LOW, o_peak <= peak. o_peak is otherwise held.
- Counter is 4 bits and never wraps: it is cleared on every state change and on disqualification.
- Reset (any cycle, including mid-ARM):
  - state=LOW, cnt=0.
  - o_avg, o_avg_valid, o_above, o_rise, o_fall, o_peak and the internal peak register all 0.

## Timing

- i_sum/i_valid at edge N → o_avg/o_avg_valid at N+1 (latency 1).
- FSM evaluates o_avg at N+1 → state, o_above, o_rise/o_fall and o_peak update at N+2.
  - Total sample-to-event latency is 2 cycles after the HOLD-th qualifying sample.
- o_rise and o_fall are each high for exactly one cycle and are never high in the same cycle.
- Gaps in i_valid do not break a consecutive count; only a non-qualifying valid sample does.
- Threshold changes take effect on the next avg evaluation.

## Structure

- Shared package avg_level_pkg holds:
  - state encoding constants LOW=2'd0, ARM_HIGH=2'd1, HIGH=2'd2, ARM_LOW=2'd3;
  - default widths SUM_W/SHIFT/AVG_W.
- One natural sub-module, round_shift_sat: the combinational rounding divide and saturation, reused by the other windowed stages.
- FSM, counter and peak tracker stay in the top module.

## Test plan

- Reset/rounding:
  - After rst all outputs are 0.
  - i_sum=11 → o_avg=1; i_sum=12 → o_avg=2; i_sum=2047 → o_avg=255 (saturated); each with o_avg_valid 1 cycle after i_valid.
- Rise debounce (HOLD=4, hi=100, lo=50):
  - avg sequence 120,120,120,90,120,120,120,120 → the 90 returns the FSM to LOW.
  - o_rise pulses 2 cycles after the 8th sample; o_above=1 thereafter.
- Fall with peak:
  - From HIGH, feed avg 150,200,40,40,60,40,40,40,40.
  - The 60 returns the FSM to HIGH. o_fall pulses after the 4th consecutive 40; o_peak=200, o_above=0.
- Valid gaps: insert i_valid=0 cycles between qualifying samples → event timing shifts by gap length only, and the count is preserved.
- Inverted thresholds: hi=80, lo=120 → effective lo=80. Avg 85 while HIGH causes no fall; avg 80 ×4 causes fall.
- Reset mid-operation: assert rst while in ARM_LOW with cnt=3 → next cycle state LOW, o_above=0, o_peak=0, and no o_fall pulse.
